// File: rtl/result_display.sv
// rtl/result_display.sv - seven-segment driver showing the last captured result, test count and busy flag
// Four active-low digits are time-multiplexed; every completion pulses done_pulse and flashes digit 0's DP.

module result_display #(
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       busy,
    input  logic [7:0] result,
    input  logic [3:0] number_of_testing,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       done_pulse
);

    localparam int PS_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BC_W = $clog2(BLINK_CYCLES + 1);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(SCAN_DIV - 1);
    localparam logic [BC_W-1:0] BC_LOAD = BC_W'(BLINK_CYCLES);

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic            busy_q;
    logic [7:0]      shown_result;
    logic [3:0]      cnt_q;
    logic [PS_W-1:0] ps;
    logic [1:0]      d;
    logic [BC_W-1:0] bc;

    logic       fall;
    logic       rise;
    logic [3:0] an_next;
    logic [6:0] seg_next;
    logic       dp_next;

    assign fall = busy_q & ~busy;
    assign rise = ~busy_q & busy;

    // Output registers sample the digit selected in the current state, hence one cycle of display latency.
    always_comb begin
        seg_next = 7'h7F;
        an_next  = ~(4'b0001 << d);
        case (d)
            2'd0:    seg_next = hex7(shown_result[3:0]);
            2'd1:    seg_next = hex7(shown_result[7:4]);
            2'd2:    seg_next = hex7(cnt_q);
            default: seg_next = busy_q ? 7'h03 : 7'h7F;
        endcase
        dp_next = ~(((d == 2'd0) && (bc != '0)) || ((d == 2'd3) && busy_q));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q       <= 1'b0;
            shown_result <= 8'h00;
            cnt_q        <= 4'h0;
            ps           <= '0;
            d            <= 2'd0;
            bc           <= '0;
            an           <= 4'b1111;
            seg          <= 7'h7F;
            dp           <= 1'b1;
            done_pulse   <= 1'b0;
        end else begin
            busy_q     <= busy;
            cnt_q      <= number_of_testing;
            done_pulse <= fall;
            if (fall) begin
                shown_result <= result;
            end

            if (ps == PS_LAST) begin
                ps <= '0;
                d  <= d + 2'd1;
            end else begin
                ps <= ps + PS_W'(1);
            end

            // A new operation cancels any flash still running from the previous completion.
            if (fall) begin
                bc <= BC_LOAD;
            end else if (rise) begin
                bc <= '0;
            end else if (bc != '0) begin
                bc <= bc - BC_W'(1);
            end

            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_result_display.sv
// tb/tb_result_display.sv - directed self-checking bench for result_display
module tb_result_display;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       busy = 1'b1;
    logic [7:0] result = 8'hA5;
    logic [3:0] number_of_testing = 4'h0;

    logic [3:0] an_a, an_b;
    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b;
    logic       done_a, done_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit toggle = 1'b0;

    result_display #(.SCAN_DIV(4), .BLINK_CYCLES(10)) dut_a (
        .clk(clk), .rst(rst), .busy(busy), .result(result),
        .number_of_testing(number_of_testing),
        .an(an_a), .seg(seg_a), .dp(dp_a), .done_pulse(done_a)
    );

    result_display #(.SCAN_DIV(1), .BLINK_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst), .busy(busy), .result(result),
        .number_of_testing(number_of_testing),
        .an(an_b), .seg(seg_b), .dp(dp_b), .done_pulse(done_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (toggle) result = (result == 8'h12) ? 8'h34 : 8'h12;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    initial begin
        // reset held 3 cycles with busy high
        repeat (3) tick();
        check("rst_an_a", an_a, 4'b1111);
        check("rst_seg_a", seg_a, 7'h7F);
        check("rst_dp_a", dp_a, 1'b1);
        check("rst_done_a", done_a, 1'b0);
        check("rst_an_b", an_b, 4'b1111);

        rst = 1'b1;
        cyc = 0;
        tick();
        check("rel_an_a", an_a, 4'b1110);
        check("rel_seg_a", seg_a, 7'h40);
        check("rel_dp_a", dp_a, 1'b1);
        check("rel_an_b", an_b, 4'b1110);
        check("rel_done_a", done_a, 1'b0);

        // SCAN_DIV=1 wrap
        tick(); check("wrap_an_b2", an_b, 4'b1101);
        tick(); check("wrap_an_b3", an_b, 4'b1011);
        tick(); check("wrap_an_b4", an_b, 4'b0111);
        check("busy_seg_b", seg_b, 7'h03);
        check("busy_dp_b", dp_b, 1'b0);
        tick(); check("wrap_an_b5", an_b, 4'b1110);
        check("wrap_seg_b5", seg_b, 7'h40);

        // busy held: result toggles must not be displayed
        toggle = 1'b1;
        run_to(14);
        check("hold_an_a3", an_a, 4'b0111);
        check("hold_seg_a3", seg_a, 7'h03);
        check("hold_dp_a3", dp_a, 1'b0);
        run_to(17);
        check("hold_an_a0", an_a, 4'b1110);
        check("hold_seg_a0", seg_a, 7'h40);
        check("hold_dp_a0", dp_a, 1'b1);
        run_to(20);
        check("no_pulse_busy", done_a, 1'b0);
        toggle = 1'b0;

        // completion with 0x3B
        result = 8'h3B;
        busy = 1'b0;
        tick();
        check("cap_done_a", done_a, 1'b1);
        check("cap_done_b", done_b, 1'b1);
        check("cap_bc_load", dut_a.bc, 10);
        check("old_seg_a1", seg_a, 7'h40);
        tick();
        check("cap_done_off", done_a, 1'b0);
        check("cap_an_a1", an_a, 4'b1101);
        check("cap_seg_a1", seg_a, 7'h30);
        check("bc_dec", dut_a.bc, 9);

        // one-cycle busy pulse, aborted result 0x80 with count 5
        number_of_testing = 4'd5;
        tick();
        busy = 1'b1;
        tick();
        check("rise_bc_clr", dut_a.bc, 0);
        busy = 1'b0;
        result = 8'h80;
        tick();
        check("b_seg_d0", seg_b, 7'h03);
        check("pulse_done_a", done_a, 1'b1);
        check("reload_bc", dut_a.bc, 10);
        tick();
        check("cnt_an_a2", an_a, 4'b1011);
        check("cnt_seg_a2", seg_a, 7'h12);

        run_to(33);
        check("abort_seg_a0", seg_a, 7'h40);
        check("blink_dp_33", dp_a, 1'b0);
        tick(); check("blink_dp_34", dp_a, 1'b0);
        tick(); check("blink_dp_35", dp_a, 1'b0);
        tick(); check("blink_dp_36", dp_a, 1'b1);
        tick();
        check("abort_an_a1", an_a, 4'b1101);
        check("abort_seg_a1", seg_a, 7'h00);

        // reset in the middle of a blink
        run_to(40);
        busy = 1'b1;
        tick();
        busy = 1'b0;
        result = 8'h5C;
        tick();
        check("mid_done", done_a, 1'b1);
        tick();
        check("mid_bc", dut_a.bc, 9);
        rst = 1'b0;
        tick();
        check("mid_rst_bc", dut_a.bc, 0);
        check("mid_rst_dp", dp_a, 1'b1);
        check("mid_rst_an", an_a, 4'b1111);
        check("mid_rst_seg", seg_a, 7'h7F);
        check("mid_rst_shown", dut_a.shown_result, 8'h00);

        // falling edge coincident with reset is dropped
        busy = 1'b1;
        result = 8'hE7;
        tick();
        rst = 1'b1;
        cyc = 0;
        tick();
        check("pri_an_a", an_a, 4'b1110);
        busy = 1'b0;
        rst = 1'b0;
        tick();
        check("pri_done_a", done_a, 1'b0);
        check("pri_done_b", done_b, 1'b0);
        check("pri_shown", dut_a.shown_result, 8'h00);
        rst = 1'b1;
        cyc = 0;
        tick();
        check("pri_seg_a", seg_a, 7'h40);
        check("pri_done_after", done_a, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/result_display.md
# result_display

Seven-segment display driver that sits directly downstream of the control logic. It consumes `busy`, `result[7:0]` and `number_of_testing[3:0]`, and latches the result at every completion (falling edge of `busy`). It multiplexes four active-low digits: result high/low nibble, test count, and a busy indicator. It also flags each completion with a one-cycle `done_pulse` and a timed decimal-point flash.

## Interface
Parameters:
- `SCAN_DIV`, default 1000: clock cycles each digit stays selected; legal range ≥ 1.
- `BLINK_CYCLES`, default 50000: length of the completion flash on digit 0's DP; legal range ≥ 1.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-low reset (`rst==0` resets on the next `clk` edge).
- `busy` in 1: busy flag from the control logic.
- `result` in 8: result bus from the control logic.
- `number_of_testing` in 4: completed-test counter from the control logic.
- `an` out 4: digit anodes, active-low, one-hot-low while scanning.
- `seg` out 7: segments `{g,f,e,d,c,b,a}`, active-low.
- `dp` out 1: decimal point, active-low.
- `done_pulse` out 1: one-cycle high on each captured completion.

## Operation
- **Edge detect:** `busy_q` is `busy` registered. A falling edge is the cycle where `busy_q==1 && busy==0`.
- **Capture:** on a falling edge, `shown_result <= result`. The control logic drives `result` valid in the same cycle `busy` drops. Aborted tests also drop `busy`, so they are captured the same way.
  - While `busy` is high, `shown_result` holds. Intermediate results are never displayed.
- **Count:** `cnt_q <= number_of_testing` every cycle, unconditionally.
- **Scan:**
  - Prescaler `ps` counts 0..`SCAN_DIV`-1 and wraps to 0.
  - Digit index `d` (2 bits) increments when `ps==SCAN_DIV-1`, wrapping 3→0.
  - With `SCAN_DIV=1`, `d` advances every cycle.
- **Digit content:**
  - d=0: hex of `shown_result[3:0]`.
  - d=1: hex of `shown_result[7:4]`.
  - d=2: hex of `cnt_q`.
  - d=3: `b` (0x03) when `busy_q==1`, otherwise blank (0x7F).
- **Hex font** (`seg` values):
  - 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78.
  - 8=0x00, 9=0x10, A=0x08, b=0x03, C=0x46, d=0x21, E=0x06, F=0x0E.
- **Blink counter** `bc` (width `$clog2(BLINK_CYCLES+1)`):
  - Loaded with `BLINK_CYCLES` on a falling edge, then decrements to 0 and holds there.
  - Cleared to 0 when `busy_q==0 && busy==1` (new operation started).
  - A falling edge during an active blink reloads it.
- **DP:**
  - `dp=0` (lit) when d=0 and `bc!=0`.
  - `dp=0` (lit) when d=3 and `busy_q==1`.
  - Otherwise `dp=1`.
- **Outputs:** `an`, `seg`, `dp` and `done_pulse` are all registered.

## Timing
- **Reset values** (cycle after `clk` edge with `rst==0`):
  - Outputs: `an=4'b1111`, `seg=0x7F`, `dp=1`, `done_pulse=0`.
  - Internal state: `ps=0`, `d=0`, `shown_result=0`, `cnt_q=0`, `busy_q=0`, `bc=0`.
- **Reset priority:** reset overrides every event in the same cycle. A falling edge coincident with `rst==0` is not captured.
- **First cycle after reset release:** outputs show digit 0 of value 0 (`an=4'b1110`, `seg=0x40`).
- **Display latency:** outputs reflect `d`/`shown_result`/`cnt_q`/`busy_q`/`bc` as registered one cycle earlier. Capture to visible segments is 2 cycles when d=0.
- **done_pulse:** high exactly one cycle, the cycle after the falling-edge detection (the same cycle `shown_result` holds the new value). No pulse if `busy` is high at reset release and never falls.
- **One-cycle busy:** a `busy` pulse one cycle wide produces a rising edge then a falling edge. It is captured normally and `done_pulse` fires.
- **Blink duration:** DP on digit 0 is enabled for exactly `BLINK_CYCLES` cycles after the load. It is visible only while d=0.
- **Scan period:** each anode is low for `SCAN_DIV` consecutive cycles; full frame = 4·`SCAN_DIV` cycles.

## Test plan
- **Reset:** hold `rst=0` 3 cycles with `busy=1`, `result=0xA5` → `an=1111`, `seg=0x7F`, `dp=1`, `done_pulse=0`. After release → `an=1110`, `seg=0x40`.
- **Completion capture:** `SCAN_DIV=4`; `busy` 1→0 with `result=0x3B` → one `done_pulse`.
  - Digit 0 shows `b` (0x03), digit 1 shows `3` (0x30).
  - DP lit on digit 0 for `BLINK_CYCLES` cycles.
- **Hold while busy:** while `busy=1`, `result` toggles 0x12/0x34 → digits 0/1 stay at the previously captured value; digit 3 shows 0x03 with DP lit.
- **Abort plus count:** `number_of_testing=5`, then `busy` drops with `result=0x80` → digit 2=0x12, digit 1=0x00, digit 0=0x40.
- **Scan wrap:** `SCAN_DIV=1` → `an` sequence 1110, 1101, 1011, 0111, 1110 on consecutive cycles.
- **Blink reload and reset mid-operation:**
  - `BLINK_CYCLES=10`; a second falling edge 4 cycles after the first → DP active for 10 cycles from the second edge.
  - Assert `rst=0` mid-blink → `bc=0`, `dp=1` next cycle.
